// File: rtl/soc_pkg.sv
// Shared SoC definitions for the UART transmitter: serialiser states,
// register indices and STATUS bit positions.
package soc_pkg;

    typedef enum logic [1:0] {
        UTIdle,
        UTStart,
        UTData,
        UTStop
    } UartTxState;

    localparam logic [1:0] UART_DATA   = 2'd0;
    localparam logic [1:0] UART_STATUS = 2'd1;
    localparam logic [1:0] UART_BAUD   = 2'd2;
    localparam logic [1:0] UART_CTRL   = 2'd3;

    localparam int STAT_BUSY      = 0;
    localparam int STAT_FULL      = 1;
    localparam int STAT_EMPTY     = 2;
    localparam int STAT_PENDING   = 3;
    localparam int STAT_COUNT_LSB = 4;

    // Packs the low byte of the STATUS register from its individual flags.
    function automatic logic [7:0] status_byte(input logic       busy,
                                               input logic       full,
                                               input logic       empty,
                                               input logic       pending,
                                               input logic [3:0] count);
        logic [7:0] s;
        s                                  = '0;
        s[STAT_BUSY]                       = busy;
        s[STAT_FULL]                       = full;
        s[STAT_EMPTY]                      = empty;
        s[STAT_PENDING]                    = pending;
        s[STAT_COUNT_LSB+3:STAT_COUNT_LSB] = count;
        return s;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO holding bytes waiting to be serialised.
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int FIFO_DEPTH = 4,
    parameter int WIDTH      = 8,
    localparam int AW        = $clog2(FIFO_DEPTH),
    localparam int CW        = AW + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    // Storage array; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/io_uart_tx.sv
// Memory-mapped UART transmitter (8N1, LSB first) behind the FemtoRV32
// mem_* target interface. Registers: DATA, STATUS, BAUD and, when the
// UART_TX_IRQ_EN macro is defined, CTRL with a registered TX-idle interrupt.
module io_uart_tx
    import soc_pkg::*;
#(
    parameter int FIFO_DEPTH      = 4,
    parameter int DIV_WIDTH       = 16,
    parameter int DEFAULT_DIVISOR = 417
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sel,
    input  logic [7:0]  addr,
    input  logic [31:0] wdata,
    input  logic [3:0]  wmask,
    input  logic        rstrb,
    output logic [31:0] rdata,
    output logic        rbusy,
    output logic        wbusy,
    output logic        tx,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0]           reg_idx;
    logic                 wr_any;
    logic                 data_write;
    logic                 baud_write;

    logic                 fifo_push;
    logic                 fifo_pop;
    logic [7:0]           fifo_din;
    logic [7:0]           fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;
    logic [3:0]           count4;

    logic                 pending_valid;
    logic [7:0]           pending_byte;

    logic [DIV_WIDTH-1:0] baud;
    logic [DIV_WIDTH-1:0] baud_merged;
    logic [DIV_WIDTH-1:0] reload;

    UartTxState           state;
    UartTxState           state_next;
    logic [7:0]           shift_reg;
    logic [7:0]           shift_next;
    logic [2:0]           bit_idx;
    logic [2:0]           bit_next;
    logic [DIV_WIDTH-1:0] baud_cnt;
    logic [DIV_WIDTH-1:0] cnt_next;
    logic                 tx_reg;
    logic                 tx_next;

    logic [31:0]          read_value;
    logic                 unused_bits;

    assign reg_idx    = addr[3:2];
    assign wr_any     = sel && (wmask != 4'b0000);
    assign data_write = wr_any && (reg_idx == UART_DATA) && wmask[0];
    assign baud_write = wr_any && (reg_idx == UART_BAUD) && (wmask[1:0] != 2'b00);

    // A pending byte takes priority: it enters the FIFO in the very cycle a pop frees a slot.
    assign fifo_push = (pending_valid && fifo_pop) ||
                       (data_write && !fifo_full && !pending_valid);
    assign fifo_din  = pending_valid ? pending_byte : wdata[7:0];

    assign rbusy       = 1'b0;
    assign wbusy       = pending_valid;
    assign tx          = tx_reg;
    assign reload      = baud - DIV_WIDTH'(1);
    assign count4      = 4'(fifo_count);
    assign unused_bits = &{1'b0, addr[7:4], addr[1:0], wdata[31:16]};

    uart_tx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .WIDTH      (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (fifo_push),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // One-deep overflow slot that stalls the CPU while the FIFO is full.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending_valid <= 1'b0;
            pending_byte  <= 8'h00;
        end else if (pending_valid && fifo_pop) begin
            pending_valid <= 1'b0;
        end else if (data_write && fifo_full && !pending_valid) begin
            pending_valid <= 1'b1;
            pending_byte  <= wdata[7:0];
        end
    end

    // Merge byte-lane writes into the divisor; a zero divisor would stall the line, so it becomes 1.
    always_comb begin
        baud_merged = baud;
        for (int i = 0; i < DIV_WIDTH; i++) begin
            if ((i < 8) && wmask[0]) begin
                baud_merged[i] = wdata[i];
            end else if ((i >= 8) && (i < 16) && wmask[1]) begin
                baud_merged[i] = wdata[i];
            end
        end
        if (baud_merged == '0) begin
            baud_merged = DIV_WIDTH'(1);
        end
    end

    // Baud divisor register; the serialiser only samples it at bit boundaries.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud <= DIV_WIDTH'(DEFAULT_DIVISOR);
        end else if (baud_write) begin
            baud <= baud_merged;
        end
    end

    // Serialiser next-state: each bit lasts baud cycles, STOP chains straight into the next START.
    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        bit_next   = bit_idx;
        cnt_next   = baud_cnt;
        tx_next    = tx_reg;
        fifo_pop   = 1'b0;
        case (state)
            UTIdle: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_next = fifo_dout;
                    cnt_next   = reload;
                    tx_next    = 1'b0;
                    state_next = UTStart;
                end
            end
            UTStart: begin
                if (baud_cnt == '0) begin
                    tx_next    = shift_reg[0];
                    bit_next   = 3'd0;
                    cnt_next   = reload;
                    state_next = UTData;
                end else begin
                    cnt_next = baud_cnt - DIV_WIDTH'(1);
                end
            end
            UTData: begin
                if (baud_cnt == '0) begin
                    cnt_next = reload;
                    if (bit_idx == 3'd7) begin
                        tx_next    = 1'b1;
                        state_next = UTStop;
                    end else begin
                        shift_next = {1'b0, shift_reg[7:1]};
                        tx_next    = shift_reg[1];
                        bit_next   = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_next = baud_cnt - DIV_WIDTH'(1);
                end
            end
            UTStop: begin
                if (baud_cnt == '0) begin
                    if (!fifo_empty) begin
                        fifo_pop   = 1'b1;
                        shift_next = fifo_dout;
                        cnt_next   = reload;
                        tx_next    = 1'b0;
                        state_next = UTStart;
                    end else begin
                        state_next = UTIdle;
                    end
                end else begin
                    cnt_next = baud_cnt - DIV_WIDTH'(1);
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = UTIdle;
            end
        endcase
    end

    // Serialiser state register together with its shift/count datapath; tx idles high.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= UTIdle;
            shift_reg <= 8'h00;
            bit_idx   <= 3'd0;
            baud_cnt  <= '0;
            tx_reg    <= 1'b1;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_idx   <= bit_next;
            baud_cnt  <= cnt_next;
            tx_reg    <= tx_next;
        end
    end

`ifdef UART_TX_IRQ_EN
    logic irq_enable;
    logic irq_reg;

    // CTRL register holding the interrupt enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_enable <= 1'b0;
        end else if (wr_any && (reg_idx == UART_CTRL) && wmask[0]) begin
            irq_enable <= wdata[0];
        end
    end

    // Interrupt fires once the transmitter has fully drained and gone idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_reg <= 1'b0;
        end else begin
            irq_reg <= irq_enable && fifo_empty && (state == UTIdle);
        end
    end

    assign irq = irq_reg;
`else
    assign irq = 1'b0;
`endif

    // Register read multiplexer; DATA and unused indices read as zero.
    always_comb begin
        read_value = 32'h0000_0000;
        case (reg_idx)
            UART_STATUS: read_value = {24'h000000,
                                       status_byte(state != UTIdle, fifo_full, fifo_empty,
                                                   pending_valid, count4)};
            UART_BAUD:   read_value = 32'(baud);
`ifdef UART_TX_IRQ_EN
            UART_CTRL:   read_value = {31'h0, irq_enable};
`endif
            default:     read_value = 32'h0000_0000;
        endcase
    end

    // Registered read data, held until the next read strobe.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= 32'h0000_0000;
        end else if (sel && rstrb) begin
            rdata <= read_value;
        end
    end

`ifndef SYNTHESIS
    a_no_write_while_pending: assert property (@(posedge clk) disable iff (!reset)
        !(data_write && pending_valid));
`endif

endmodule

// File: tb/tb_io_uart_tx.sv
// Randomised scoreboard bench for io_uart_tx: expected bytes and read values
// are queued by the stimulus and checked by independent monitor processes.
module tb_io_uart_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        sel;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic        rstrb;
    logic [31:0] rdata;
    logic        rbusy;
    logic        wbusy;
    logic        tx;
    logic        irq;

    typedef struct {
        logic [31:0] value;
        string       tag;
    } rd_exp_t;

    int           vec_cnt = 0;
    int           miscompares = 0;
    int           cycle = 0;
    int           cur_baud = 417;
    byte unsigned exp_q[$];
    int           start_q[$];
    rd_exp_t      rd_q[$];

    io_uart_tx dut (
        .clk   (clk),
        .reset (reset),
        .sel   (sel),
        .addr  (addr),
        .wdata (wdata),
        .wmask (wmask),
        .rstrb (rstrb),
        .rdata (rdata),
        .rbusy (rbusy),
        .wbusy (wbusy),
        .tx    (tx),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle++;

    initial begin
        #600000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vec_cnt++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    task automatic report_fail(input string name, input string why);
        vec_cnt++;
        miscompares++;
        $display("[TB] FAIL %s: %s", name, why);
    endtask

    task automatic bus_idle();
        sel   = 1'b0;
        addr  = 8'h00;
        wdata = 32'h0;
        wmask = 4'h0;
        rstrb = 1'b0;
    endtask

    task automatic write_reg(input logic [1:0] idx, input logic [31:0] data, input logic [3:0] mask);
        @(negedge clk);
        sel   = 1'b1;
        addr  = {4'h0, idx, 2'b00};
        wdata = data;
        wmask = mask;
        rstrb = 1'b0;
        @(negedge clk);
        bus_idle();
    endtask

    task automatic read_reg(input logic [1:0] idx, input logic [31:0] expected, input string tag);
        @(negedge clk);
        sel   = 1'b1;
        addr  = {4'h0, idx, 2'b00};
        rstrb = 1'b1;
        rd_q.push_back('{value: expected, tag: tag});
        @(negedge clk);
        bus_idle();
    endtask

    task automatic set_baud(input logic [15:0] val);
        write_reg(2'd2, {16'h0, val}, 4'b0011);
        cur_baud = (val == 16'h0) ? 1 : int'(val);
    endtask

    task automatic send_byte(input byte unsigned b);
        int guard;
        guard = 0;
        while (wbusy === 1'b1 && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) report_fail("send_wbusy_wait", "wbusy never released");
        exp_q.push_back(b);
        write_reg(2'd0, {24'h0, b}, 4'b0001);
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 20000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 20000) begin
            report_fail("drain_timeout", "expected bytes never appeared on tx");
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    // Serial-line monitor: samples every bit slot for cur_baud cycles and rebuilds the byte.
    initial begin : tx_monitor
        logic [9:0] slot;
        bit         stable;
        bit         aborted;
        int         st;
        int         b;
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && tx === 1'b0) begin
                slot    = '0;
                stable  = 1'b1;
                aborted = 1'b0;
                st      = cycle;
                b       = cur_baud;
                for (int p = 0; p < 10 && !aborted; p++) begin
                    for (int s = 0; s < b && !aborted; s++) begin
                        if (!(p == 0 && s == 0)) @(negedge clk);
                        if (reset !== 1'b1) aborted = 1'b1;
                        else if (s == 0) slot[p] = tx;
                        else if (tx !== slot[p]) stable = 1'b0;
                    end
                end
                if (!aborted) begin
                    start_q.push_back(st);
                    check_output("frame_bit_timing", {31'h0, stable}, 32'h1);
                    check_output("stop_bit", {31'h0, slot[9]}, 32'h1);
                    if (exp_q.size() == 0) report_fail("unexpected_frame", "frame seen with no byte queued");
                    else check_output("tx_byte", {24'h0, slot[8:1]}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    // Read-data monitor: a strobe at a rising edge must present its value by the next falling edge.
    initial begin : rd_monitor
        bit      strobed;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            strobed = (sel === 1'b1) && (rstrb === 1'b1) && (reset === 1'b1);
            @(negedge clk);
            if (strobed) begin
                if (rd_q.size() == 0) begin
                    report_fail("unexpected_read", "strobe without queued expectation");
                end else begin
                    e = rd_q.pop_front();
                    check_output(e.tag, rdata, e.value);
                end
            end
        end
    end

    initial begin : apply_stimulus
        byte unsigned burst [6];
        int           k;
        bit           any_high;

        bus_idle();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check_output("reset_tx", {31'h0, tx}, 32'h1);
        check_output("reset_wbusy", {31'h0, wbusy}, 32'h0);
        check_output("reset_rdata", rdata, 32'h0);
        check_output("reset_irq", {31'h0, irq}, 32'h0);
        check_output("rbusy", {31'h0, rbusy}, 32'h0);
        reset = 1'b1;

        read_reg(2'd1, 32'h0000_0004, "status_after_reset");
        read_reg(2'd2, 32'd417, "baud_after_reset");
        read_reg(2'd0, 32'h0, "data_reads_zero");

        // Single frame at BAUD=4 with the classic 0xA5 pattern.
        set_baud(16'd4);
        send_byte(8'hA5);
        read_reg(2'd1, 32'h0000_0005, "status_busy_empty");
        wait_drain();
        read_reg(2'd1, 32'h0000_0004, "status_idle_after_a5");

        // Back-to-back burst of six random bytes at BAUD=2.
        set_baud(16'd2);
        start_q.delete();
        for (int i = 0; i < 6; i++) burst[i] = byte'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 5) check_output("wbusy_low_before_overflow", {31'h0, wbusy}, 32'h0);
            sel   = 1'b1;
            addr  = 8'h00;
            wdata = {24'h0, burst[i]};
            wmask = 4'b0001;
            exp_q.push_back(burst[i]);
        end
        @(negedge clk);
        bus_idle();
        check_output("wbusy_raised", {31'h0, wbusy}, 32'h1);
        k = 0;
        while (wbusy === 1'b1 && k < 500) begin
            @(negedge clk);
            k++;
        end
        check_output("wbusy_drop_cycles", k, 10 * cur_baud - 4);
        wait_drain();
        check_output("burst_frame_count", start_q.size(), 6);
        for (int i = 1; i < 6 && i < start_q.size(); i++) begin
            check_output("burst_no_gap", start_q[i] - start_q[i-1], 10 * cur_baud);
        end
        read_reg(2'd1, 32'h0000_0004, "status_idle_after_burst");

        // Zero divisor is stored as one: one cycle per bit.
        set_baud(16'd0);
        read_reg(2'd2, 32'd1, "baud_zero_reads_one");
        send_byte(byte'($urandom_range(0, 255)));
        wait_drain();

        // A few random divisor/byte pairs.
        for (int i = 0; i < 3; i++) begin
            set_baud(16'($urandom_range(1, 6)));
            read_reg(2'd2, cur_baud, "baud_readback");
            send_byte(byte'($urandom_range(0, 255)));
            wait_drain();
        end

        // Asynchronous reset in the middle of data bit 3 with another byte still queued.
        set_baud(16'd4);
        send_byte(8'h3C);
        send_byte(byte'($urandom_range(0, 255)));
        repeat (16) @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_output("async_reset_tx", {31'h0, tx}, 32'h1);
        check_output("async_reset_wbusy", {31'h0, wbusy}, 32'h0);
        exp_q.delete();
        cur_baud = 417;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        read_reg(2'd1, 32'h0000_0004, "status_after_async_reset");
        read_reg(2'd2, 32'd417, "baud_after_async_reset");

`ifdef UART_TX_IRQ_EN
        set_baud(16'd2);
        write_reg(2'd3, 32'h1, 4'b0001);
        @(negedge clk);
        check_output("irq_idle_enabled", {31'h0, irq}, 32'h1);
        read_reg(2'd3, 32'h1, "ctrl_readback");
        send_byte(byte'($urandom_range(0, 255)));
        any_high = 1'b0;
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            if (irq !== 1'b0) any_high = 1'b1;
        end
        check_output("irq_low_during_frame", {31'h0, any_high}, 32'h0);
        @(negedge clk);
        check_output("irq_after_idle", {31'h0, irq}, 32'h1);
        wait_drain();
`else
        write_reg(2'd3, 32'h1, 4'b0001);
        read_reg(2'd3, 32'h0, "reserved_reads_zero");
        set_baud(16'd2);
        send_byte(byte'($urandom_range(0, 255)));
        any_high = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (irq !== 1'b0) any_high = 1'b1;
        end
        check_output("irq_tied_low", {31'h0, any_high}, 32'h0);
        wait_drain();
`endif

        repeat (4) @(negedge clk);
        if (rd_q.size() != 0) report_fail("reads_outstanding", "queued read expectations never checked");
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
        $finish;
    end

endmodule
